// File: rtl/fsm_out_pkg.sv
// Shared sensor codes and exit-FSM state encoding for the parking-lot gate.
// Used by both the entry and exit direction detectors.
package parking_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        OUTER = 2'b01,
        INNER = 2'b10,
        BOTH  = 2'b11
    } sensor_t;

    // Tracking states reuse the sensor code; bit 2 marks IDLE/FOREIGN
    typedef enum logic [2:0] {
        S_X1      = 3'b001,
        S_X3      = 3'b010,
        S_X2      = 3'b011,
        S_IDLE    = 3'b100,
        S_FOREIGN = 3'b111
    } state_t;

    function automatic sensor_t to_code(input logic a, input logic b);
        return sensor_t'({a, b});
    endfunction

endpackage

// File: rtl/fsm_out_if.sv
// Sensor inputs and event outputs of the exit detector.
// master drives the beams, slave is the detector.
interface fsm_out_if;
    logic a;
    logic b;
    logic y;
    logic abort;
    logic err;
    logic stuck;

    modport master (
        output a, b,
        input  y, abort, err, stuck
    );

    modport slave (
        input  a, b,
        output y, abort, err, stuck
    );
endinterface

// File: rtl/fsm_out_sensor_stall_timer.sv
// Saturating count of consecutive blocked samples.
// stuck_rise flags the sample that makes the count reach STALL_MAX.
module sensor_stall_timer #(
    parameter int STALL_MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic blocked,
    output logic stuck,
    output logic stuck_rise
);
    localparam int W = $clog2(STALL_MAX + 1);
    localparam logic [W-1:0] MAX = W'(STALL_MAX);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!blocked) begin
            r_cnt <= '0;
        end else if (r_cnt != MAX) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign stuck      = (r_cnt == MAX);
    assign stuck_rise = blocked && (r_cnt == MAX - ONE);
endmodule

// File: rtl/fsm_out.sv
// Exit-direction detector: pulses y on b -> ab -> a -> clear,
// with abort, err and stuck reporting.
module fsm_out
    import parking_pkg::*;
#(
    parameter int STALL_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    fsm_out_if.slave   bus
);
    sensor_t w_code;
    state_t  r_state;
    state_t  w_next;
    logic    w_y;
    logic    w_abort;
    logic    w_err;
    logic    w_stuck;
    logic    w_stuck_rise;
    logic    r_y;
    logic    r_abort;
    logic    r_err;

    assign w_code = to_code(bus.a, bus.b);

    sensor_stall_timer #(
        .STALL_MAX (STALL_MAX)
    ) u_stall (
        .clk        (clk),
        .reset      (reset),
        .blocked    (w_code != CLEAR),
        .stuck      (w_stuck),
        .stuck_rise (w_stuck_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_y     <= 1'b0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_y     <= w_y;
            r_abort <= w_abort;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_y     = 1'b0;
        w_abort = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                unique case (w_code)
                    CLEAR: w_next = S_IDLE;
                    OUTER: w_next = S_X1;
                    INNER: w_next = S_FOREIGN;
                    BOTH: begin
                        w_next = S_FOREIGN;
                        w_err  = 1'b1;
                    end
                endcase
            end
            S_X1: begin
                unique case (w_code)
                    OUTER: w_next = S_X1;
                    BOTH:  w_next = S_X2;
                    CLEAR: begin
                        w_next  = S_IDLE;
                        w_abort = 1'b1;
                    end
                    INNER: begin
                        w_next = S_FOREIGN;
                        w_err  = 1'b1;
                    end
                endcase
            end
            S_X2: begin
                unique case (w_code)
                    BOTH:  w_next = S_X2;
                    INNER: w_next = S_X3;
                    OUTER: w_next = S_X1;
                    CLEAR: begin
                        w_next = S_FOREIGN;
                        w_err  = 1'b1;
                    end
                endcase
            end
            S_X3: begin
                unique case (w_code)
                    INNER: w_next = S_X3;
                    BOTH:  w_next = S_X2;
                    CLEAR: begin
                        w_next = S_IDLE;
                        w_y    = 1'b1;
                    end
                    OUTER: begin
                        w_next = S_FOREIGN;
                        w_err  = 1'b1;
                    end
                endcase
            end
            default: begin
                if (w_code == CLEAR) w_next = S_IDLE;
            end
        endcase
        // A stall overrides whatever the table decided, silently
        if (w_stuck_rise) begin
            w_next  = S_FOREIGN;
            w_y     = 1'b0;
            w_abort = 1'b0;
            w_err   = 1'b0;
        end
    end

    assign bus.y     = r_y;
    assign bus.abort = r_abort;
    assign bus.err   = r_err;
    assign bus.stuck = w_stuck;
endmodule

// File: tb/tb_fsm_out.sv
// Directed bench for fsm_out: expectations queued per sample,
// checked one edge later on a default and a STALL_MAX=8 instance.
module tb_fsm_out;
    typedef struct {
        logic       sel8;
        logic [3:0] exp;
        string      tag;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    sb_t  q[$];

    fsm_out_if ifd ();
    fsm_out_if if8 ();

    fsm_out dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifd.slave)
    );

    fsm_out #(
        .STALL_MAX (8)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    always #5 clk = ~clk;

    // Drive one sample; exp = {y,abort,err,stuck} expected after the edge
    task automatic step(input logic [1:0] code, input logic rst,
                        input logic sel8, input logic [3:0] exp,
                        input string tag);
        sb_t e;
        sb_t g;
        logic [3:0] obs;
        ifd.a = code[1];
        ifd.b = code[0];
        if8.a = code[1];
        if8.b = code[0];
        reset = rst;
        e.sel8 = sel8;
        e.exp = exp;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        total++;
        if (q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            g = q.pop_front();
            if (g.sel8)
                obs = {if8.y, if8.abort, if8.err, if8.stuck};
            else
                obs = {ifd.y, ifd.abort, ifd.err, ifd.stuck};
            assert (obs === g.exp) else begin
                bad++;
                $error("FAIL %s got=%b want=%b", g.tag, obs, g.exp);
            end
        end
    endtask

    task automatic hold(input logic [1:0] code, input int n,
                        input string tag);
        for (int i = 0; i < n; i++) step(code, 1'b0, 1'b0, 4'b0000, tag);
    endtask

    initial begin
        ifd.a = 1'b0;
        ifd.b = 1'b0;
        if8.a = 1'b0;
        if8.b = 1'b0;
        @(negedge clk);
        step(2'b00, 1'b1, 1'b0, 4'b0000, "reset_dflt");
        step(2'b00, 1'b1, 1'b1, 4'b0000, "reset_s8");

        // exit with each code held 3 cycles
        hold(2'b00, 3, "exit_clr");
        hold(2'b01, 3, "exit_01");
        hold(2'b11, 3, "exit_11");
        hold(2'b10, 3, "exit_10");
        step(2'b00, 1'b0, 1'b0, 4'b1000, "exit_y");
        hold(2'b00, 2, "exit_after");

        // entry sequence ignored
        hold(2'b10, 1, "entry_10");
        hold(2'b11, 1, "entry_11");
        hold(2'b01, 1, "entry_01");
        hold(2'b00, 1, "entry_00");

        // reversal then abort
        hold(2'b01, 1, "rev_01");
        hold(2'b11, 1, "rev_11");
        hold(2'b10, 1, "rev_10");
        hold(2'b11, 1, "rev_11b");
        hold(2'b01, 1, "rev_01b");
        step(2'b00, 1'b0, 1'b0, 4'b0100, "rev_abort");

        // back-to-back exits, y four cycles apart
        for (int k = 0; k < 2; k++) begin
            hold(2'b01, 1, "b2b_01");
            hold(2'b11, 1, "b2b_11");
            hold(2'b10, 1, "b2b_10");
            step(2'b00, 1'b0, 1'b0, 4'b1000, "b2b_y");
        end

        // illegal jump, foreign traffic, then fresh exit
        step(2'b11, 1'b0, 1'b0, 4'b0010, "jump_err");
        hold(2'b01, 1, "jump_f01");
        hold(2'b11, 1, "jump_f11");
        hold(2'b10, 1, "jump_f10");
        hold(2'b00, 1, "jump_f00");
        hold(2'b01, 1, "jump_01");
        hold(2'b11, 1, "jump_11");
        hold(2'b10, 1, "jump_10");
        step(2'b00, 1'b0, 1'b0, 4'b1000, "jump_y");

        // X1 -> 10 and X3 -> 01 illegal jumps
        hold(2'b01, 1, "ill_01");
        step(2'b10, 1'b0, 1'b0, 4'b0010, "ill_x1_10");
        hold(2'b00, 1, "ill_clr");
        hold(2'b01, 1, "ill_01b");
        hold(2'b11, 1, "ill_11");
        hold(2'b10, 1, "ill_10");
        step(2'b01, 1'b0, 1'b0, 4'b0010, "ill_x3_01");
        hold(2'b00, 1, "ill_clr2");

        // reset while in X3 drops the exit
        hold(2'b01, 1, "rst_01");
        hold(2'b11, 1, "rst_11");
        hold(2'b10, 1, "rst_10");
        step(2'b10, 1'b1, 1'b0, 4'b0000, "rst_mid");
        step(2'b00, 1'b0, 1'b0, 4'b0000, "rst_no_y");
        hold(2'b00, 1, "rst_idle");

        // stall on the STALL_MAX=8 instance
        step(2'b00, 1'b1, 1'b1, 4'b0000, "st_reset");
        step(2'b00, 1'b0, 1'b1, 4'b0000, "st_clr");
        step(2'b01, 1'b0, 1'b1, 4'b0000, "st_01");
        for (int i = 0; i < 6; i++)
            step(2'b11, 1'b0, 1'b1, 4'b0000, "st_pre");
        step(2'b11, 1'b0, 1'b1, 4'b0001, "st_rise");
        for (int i = 0; i < 5; i++)
            step(2'b11, 1'b0, 1'b1, 4'b0001, "st_held");
        step(2'b00, 1'b0, 1'b1, 4'b0000, "st_fall");
        step(2'b01, 1'b0, 1'b1, 4'b0000, "st_x01");
        step(2'b11, 1'b0, 1'b1, 4'b0000, "st_x11");
        step(2'b10, 1'b0, 1'b1, 4'b0000, "st_x10");
        step(2'b00, 1'b0, 1'b1, 4'b1000, "st_x_y");

        // stall forced on an X2 -> X3 edge: no y afterwards
        step(2'b01, 1'b0, 1'b1, 4'b0000, "sf_01");
        for (int i = 0; i < 6; i++)
            step(2'b11, 1'b0, 1'b1, 4'b0000, "sf_11");
        step(2'b10, 1'b0, 1'b1, 4'b0001, "sf_force");
        step(2'b00, 1'b0, 1'b1, 4'b0000, "sf_no_y");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
